// File: rtl/skinny_dom_pkg.sv
// rtl/skinny_dom_pkg.sv - shared constants and state type for the DOM-masked SKINNY SubCells slice
//
// Purpose : constants shared by the serial masked SubCells layer, its PRNG
//           and its masked S-box.
// Contents: CELLS, SBOX_LAT, RND_W, LFSR_W and the controller state enum.
package skinny_dom_pkg;

  localparam int CELLS    = 16;  // byte cells in a 128-bit state
  localparam int SBOX_LAT = 2;   // cycles the S-box inputs must be held
  localparam int RND_W    = 25;  // fresh random bits per S-box evaluation
  localparam int LFSR_W   = 31;  // PRNG state width

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

endpackage

// File: rtl/skinny_prng25.sv
// rtl/skinny_prng25.sv - 31-bit Fibonacci LFSR advancing 25 steps per request
//
// Purpose : randomness source for the masked S-box; x^31+x^28+1, 25 steps
//           unrolled so each S-box evaluation sees disjoint bits.
// Ports   : clk, rst_n (async, active-low)
//           step  - advance the LFSR by 25 steps
//           load  - reload from seed (zero seed is replaced by SEED)
//           seed  - reload value
//           rnd   - current LFSR[24:0]
module skinny_prng25
  import skinny_dom_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 31'h5A5A_1234
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [RND_W-1:0]  rnd
);

  logic [LFSR_W-1:0] lfsr_q;

  // Shift left, feedback from taps 31 and 28 (bits 30 and 27).
  function automatic logic [LFSR_W-1:0] advance25(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] t;
    t = s;
    for (int i = 0; i < RND_W; i++) begin
      t = {t[LFSR_W-2:0], t[LFSR_W-1] ^ t[LFSR_W-4]};
    end
    return t;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (load) begin
      // An all-zero state would lock the LFSR, so fall back to SEED.
      lfsr_q <= (seed == '0) ? SEED : seed;
    end else if (step) begin
      lfsr_q <= advance25(lfsr_q);
    end
  end

  assign rnd = lfsr_q[RND_W-1:0];

endmodule

// File: rtl/skinny_sbox8_dom1_rapid_non_pipelined.sv
// rtl/skinny_sbox8_dom1_rapid_non_pipelined.sv - first-order DOM SKINNY 8-bit S-box, 2-cycle latency
//
// Purpose : two-share SKINNY S8. Four NOR/permute rounds; rounds 1-2 feed a
//           refreshed share register, rounds 3-4 are combinational from it.
//           Inputs and r must be held for two cycles.
// Ports   : clk, rst_n (async, active-low)
//           x0, x1 - input shares
//           r      - 25 fresh random bits
//           y0, y1 - output shares
module skinny_sbox8_dom1_rapid_non_pipelined
  import skinny_dom_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       x0,
  input  logic [7:0]       x1,
  input  logic [RND_W-1:0] r,
  output logic [7:0]       y0,
  output logic [7:0]       y1
);

  // One masked round: bit4 ^= NOR(b7,b6), bit0 ^= NOR(b3,b2).
  // NOR(a,b) = ~a & ~b; negating a shared value flips only share 0, so
  // own_inv marks share 0 and oth6/oth2 arrive already adjusted.
  // The cross-domain product is blinded with the gate's random bit.
  function automatic logic [7:0] nor_layer(input logic [7:0] own, input logic own_inv,
                                           input logic oth6, input logic oth2,
                                           input logic [1:0] rr);
    logic [7:0] res;
    logic n7, n6, n3, n2;
    n7 = own[7] ^ own_inv;
    n6 = own[6] ^ own_inv;
    n3 = own[3] ^ own_inv;
    n2 = own[2] ^ own_inv;
    res    = own;
    res[4] = own[4] ^ (n7 & n6) ^ ((n7 & oth6) ^ rr[1]);
    res[0] = own[0] ^ (n3 & n2) ^ ((n3 & oth2) ^ rr[0]);
    return res;
  endfunction

  function automatic logic [7:0] perm(input logic [7:0] b);
    return {b[2], b[1], b[7], b[6], b[4], b[0], b[3], b[5]};
  endfunction

  // Final round swaps bits 1 and 2 instead of the full permutation.
  function automatic logic [7:0] swap12(input logic [7:0] b);
    return {b[7:3], b[1], b[2], b[0]};
  endfunction

  logic [7:0] l1_0, l1_1, l2_0, l2_1;
  logic [7:0] mid0_q, mid1_q;
  logic [7:0] l3_0, l3_1, l4_0, l4_1;
  logic [7:0] m_mid;

  assign l1_0 = perm(nor_layer(x0, 1'b1, x1[6], x1[2], r[1:0]));
  assign l1_1 = perm(nor_layer(x1, 1'b0, ~x0[6], ~x0[2], r[1:0]));
  assign l2_0 = perm(nor_layer(l1_0, 1'b1, l1_1[6], l1_1[2], r[3:2]));
  assign l2_1 = perm(nor_layer(l1_1, 1'b0, ~l1_0[6], ~l1_0[2], r[3:2]));

  // r[24] is folded into the mid refresh so every supplied bit is consumed.
  assign m_mid = r[15:8] ^ {8{r[24]}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid0_q <= '0;
      mid1_q <= '0;
    end else begin
      mid0_q <= l2_0 ^ m_mid;
      mid1_q <= l2_1 ^ m_mid;
    end
  end

  assign l3_0 = perm(nor_layer(mid0_q, 1'b1, mid1_q[6], mid1_q[2], r[5:4]));
  assign l3_1 = perm(nor_layer(mid1_q, 1'b0, ~mid0_q[6], ~mid0_q[2], r[5:4]));
  assign l4_0 = swap12(nor_layer(l3_0, 1'b1, l3_1[6], l3_1[2], r[7:6]));
  assign l4_1 = swap12(nor_layer(l3_1, 1'b0, ~l3_0[6], ~l3_0[2], r[7:6]));

  assign y0 = l4_0 ^ r[23:16];
  assign y1 = l4_1 ^ r[23:16];

endmodule

// File: rtl/skinny_subcells_dom1_serial.sv
// rtl/skinny_subcells_dom1_serial.sv - serial two-share SKINNY SubCells layer, one cell per 2 cycles
//
// Purpose : runs the 16 cells of a masked 128-bit state through one DOM
//           S-box, cell 0 = bits [127:120] first; 32 cycles per state.
// Ports   : clk, rst_n (async, active-low)
//           start       - begin a run (IDLE only), latches si0/si1
//           si0, si1    - input shares
//           seed_ld     - reload PRNG from seed (IDLE only)
//           seed        - PRNG reload value
//           so0, so1    - registered output shares
//           busy        - run in progress
//           done        - one-cycle pulse when so0/so1 are complete
module skinny_subcells_dom1_serial
  import skinny_dom_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 31'h5A5A_1234
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [127:0]      si0,
  input  logic [127:0]      si1,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  output logic [127:0]      so0,
  output logic [127:0]      so1,
  output logic              busy,
  output logic              done
);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic             ph_q;
  logic [127:0]     sh0_q, sh1_q;
  logic [127:0]     so0_q, so1_q;
  logic             done_q;
  logic             accept, capture, last_cell, lfsr_load;
  logic [6:0]       byte_lsb;
  logic [7:0]       sb_x0, sb_x1, sb_y0, sb_y1;
  logic [RND_W-1:0] rnd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)     state_d = EVAL;
      EVAL: if (last_cell) state_d = IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    accept    = 1'b0;
    lfsr_load = 1'b0;
    capture   = 1'b0;
    last_cell = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        accept    = start;
        lfsr_load = seed_ld;
      end
      EVAL: begin
        busy      = 1'b1;
        capture   = (ph_q == 1'(SBOX_LAT - 1));
        last_cell = capture && (cnt_q == 4'(CELLS - 1));
      end
    endcase
  end

  // Cell k sits at bits [127-8k -: 8]; 15-k equals ~k for a 4-bit index.
  assign byte_lsb = {~cnt_q, 3'b000};

  // Separate per-share byte muxes.
  assign sb_x0 = sh0_q[byte_lsb +: 8];
  assign sb_x1 = sh1_q[byte_lsb +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ph_q   <= 1'b0;
      sh0_q  <= '0;
      sh1_q  <= '0;
      so0_q  <= '0;
      so1_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_cell;
      if (accept) begin
        sh0_q <= si0;
        sh1_q <= si1;
        cnt_q <= '0;
        ph_q  <= 1'b0;
      end else if (state_q == EVAL) begin
        ph_q <= ~ph_q;
        if (capture) begin
          so0_q[byte_lsb +: 8] <= sb_y0;
          so1_q[byte_lsb +: 8] <= sb_y1;
          cnt_q                <= cnt_q + 4'd1;
        end
      end
    end
  end

  skinny_prng25 #(
    .SEED (SEED)
  ) u_prng (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (capture),
    .load  (lfsr_load),
    .seed  (seed),
    .rnd   (rnd)
  );

  skinny_sbox8_dom1_rapid_non_pipelined u_sbox (
    .clk   (clk),
    .rst_n (rst_n),
    .x0    (sb_x0),
    .x1    (sb_x1),
    .r     (rnd),
    .y0    (sb_y0),
    .y1    (sb_y1)
  );

  assign so0  = so0_q;
  assign so1  = so1_q;
  assign done = done_q;

endmodule

// File: tb/tb_skinny_subcells_dom1_serial.sv
// tb/tb_skinny_subcells_dom1_serial.sv - directed bench for the serial masked SubCells layer
module tb_skinny_subcells_dom1_serial;

  localparam logic [30:0] SEED_DEF = 31'h5A5A_1234;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] si0, si1;
  logic         seed_ld;
  logic [30:0]  seed;
  logic [127:0] so0, so1;
  logic         busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  skinny_subcells_dom1_serial dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .si0     (si0),
    .si1     (si1),
    .seed_ld (seed_ld),
    .seed    (seed),
    .so0     (so0),
    .so1     (so1),
    .busy    (busy),
    .done    (done)
  );

  // SKINNY S8: 3x (NOR round, bit permutation), then NOR round and swap of bits 1/2.
  function automatic logic [7:0] sbox_ref(input logic [7:0] v);
    logic [7:0] x;
    x = v;
    for (int it = 0; it < 4; it++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (it < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
      else        x = {x[7:3], x[1], x[2], x[0]};
    end
    return x;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] p);
    logic [127:0] q;
    for (int k = 0; k < 16; k++) q[8*k +: 8] = sbox_ref(p[8*k +: 8]);
    return q;
  endfunction

  function automatic logic [30:0] lfsr_adv(input logic [30:0] s, input int n);
    logic [30:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = {t[29:0], t[30] ^ t[27]};
    return t;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Pulses start for edge E0, then waits (bounded) for done; lat = edges after E0.
  task automatic run_op(input logic [127:0] a0, input logic [127:0] a1, output int lat);
    si0 = a0;
    si1 = a1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    seed_ld = 1'b0;
    seed = '0;
    si0 = '0;
    si1 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (so0 !== 128'h0) begin n_bad++; $display("FAIL reset_so0: got %h want 0", so0); end
    n_cmp++; if (so1 !== 128'h0) begin n_bad++; $display("FAIL reset_so1: got %h want 0", so1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++;
    if (dut.u_prng.lfsr_q !== SEED_DEF) begin
      n_bad++; $display("FAIL reset_lfsr: got %h want %h", dut.u_prng.lfsr_q, SEED_DEF);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_state();
    logic [127:0] m;
    int lat;
    m = rand128();
    run_op(m, m, lat);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL zero_latency: got %0d want 32", lat); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_in_done: got %b want 0", busy); end
    n_cmp++;
    if ((so0 ^ so1) !== {16{8'h65}}) begin
      n_bad++; $display("FAIL zero_state: got %h want %h", so0 ^ so1, {16{8'h65}});
    end
  endtask

  task automatic test_ones_state();
    logic [127:0] m;
    int lat;
    m = rand128();
    run_op(~m, m, lat);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL ones_latency: got %0d want 32", lat); end
    n_cmp++;
    if ((so0 ^ so1) !== {16{8'hFF}}) begin
      n_bad++; $display("FAIL ones_state: got %h want %h", so0 ^ so1, {16{8'hFF}});
    end
  endtask

  task automatic test_lut_sweep();
    logic [127:0] p, m, exp;
    int lat;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) p[127 - 8*k -: 8] = 8'(16*j + k);
      exp = sub_ref(p);
      m = rand128();
      run_op(p ^ m, m, lat);
      n_cmp++;
      if (lat !== 32 || (so0 ^ so1) !== exp) begin
        n_bad++; $display("FAIL lut_run%0d: got %h (lat %0d) want %h (lat 32)", j, so0 ^ so1, lat, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] p1, p2, m;
    int bad_cyc, lat;
    p1 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    p2 = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
    m = rand128();
    si0 = p1 ^ m;
    si1 = m;
    start = 1'b1;
    @(posedge clk); #1;                      // after E0
    start = 1'b0;
    bad_cyc = 0;
    if (busy !== 1'b1 || done !== 1'b0) bad_cyc++;
    for (int e = 1; e <= 31; e++) begin
      start = (e == 10);                      // sampled at E10, must be ignored
      si0 = rand128();
      @(posedge clk); #1;
      if (busy !== 1'b1 || done !== 1'b0) bad_cyc++;
    end
    start = 1'b0;
    n_cmp++; if (bad_cyc !== 0) begin n_bad++; $display("FAIL b2b_busy_window: got %0d bad cycles want 0", bad_cyc); end
    @(posedge clk); #1;                      // after E32
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_after_e32: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after_e32: got %b want 0", busy); end
    n_cmp++;
    if ((so0 ^ so1) !== sub_ref(p1)) begin
      n_bad++; $display("FAIL b2b_first_result: got %h want %h", so0 ^ so1, sub_ref(p1));
    end
    // Start issued in the done cycle.
    m = rand128();
    run_op(p2 ^ m, m, lat);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 32", lat); end
    n_cmp++;
    if ((so0 ^ so1) !== sub_ref(p2)) begin
      n_bad++; $display("FAIL b2b_second_result: got %h want %h", so0 ^ so1, sub_ref(p2));
    end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_single: got %b want 0", done); end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] p, m;
    int lat;
    m = rand128();
    si0 = 128'h00112233445566778899AABBCCDDEEFF ^ m;
    si1 = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;                                       // cell 7 presented
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (so0 !== 128'h0) begin n_bad++; $display("FAIL midrst_so0: got %h want 0", so0); end
    n_cmp++; if (so1 !== 128'h0) begin n_bad++; $display("FAIL midrst_so1: got %h want 0", so1); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL midrst_flags: got busy %b done %b want 0 0", busy, done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    p = 128'h000102030405060708090A0B0C0D0E0F;
    m = rand128();
    run_op(p ^ m, m, lat);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL midrst_restart_latency: got %0d want 32", lat); end
    n_cmp++;
    if ((so0 ^ so1) !== sub_ref(p)) begin
      n_bad++; $display("FAIL midrst_restart_result: got %h want %h", so0 ^ so1, sub_ref(p));
    end
  endtask

  task automatic test_seed_reload();
    logic [127:0] p, m, first_so0;
    int lat;
    seed = 31'h0123_4567;
    seed_ld = 1'b1;
    @(posedge clk); #1;
    seed_ld = 1'b0;
    n_cmp++;
    if (dut.u_prng.lfsr_q !== 31'h0123_4567) begin
      n_bad++; $display("FAIL seed_load_value: got %h want %h", dut.u_prng.lfsr_q, 31'h0123_4567);
    end
    seed = '0;
    seed_ld = 1'b1;
    @(posedge clk); #1;
    seed_ld = 1'b0;
    n_cmp++;
    if (dut.u_prng.lfsr_q !== SEED_DEF) begin
      n_bad++; $display("FAIL seed_zero_guard: got %h want %h", dut.u_prng.lfsr_q, SEED_DEF);
    end
    p = 128'hC0FFEE00112358132134558914233377;
    m = rand128();
    run_op(p ^ m, m, lat);
    first_so0 = so0;
    n_cmp++;
    if ((so0 ^ so1) !== sub_ref(p)) begin
      n_bad++; $display("FAIL seed_run1_result: got %h want %h", so0 ^ so1, sub_ref(p));
    end
    // Second identical run with seed_ld held during EVAL (must be ignored).
    si0 = p ^ m;
    si1 = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seed = 31'h0000_0001;
    lat = 0;
    while (!done && lat < 40) begin
      seed_ld = (lat < 6);
      @(posedge clk); #1;
      lat++;
    end
    seed_ld = 1'b0;
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL seed_run2_latency: got %0d want 32", lat); end
    n_cmp++;
    if ((so0 ^ so1) !== sub_ref(p)) begin
      n_bad++; $display("FAIL seed_run2_result: got %h want %h", so0 ^ so1, sub_ref(p));
    end
    n_cmp++;
    if (so0 === first_so0) begin
      n_bad++; $display("FAIL seed_share_refresh: got %h twice want differing share 0", so0);
    end
    n_cmp++;
    if (dut.u_prng.lfsr_q !== lfsr_adv(SEED_DEF, 800)) begin
      n_bad++; $display("FAIL seed_lfsr_after_runs: got %h want %h", dut.u_prng.lfsr_q, lfsr_adv(SEED_DEF, 800));
    end
  endtask

  initial begin
    test_reset();
    test_zero_state();
    test_ones_state();
    test_lut_sweep();
    test_back_to_back();
    test_reset_mid_run();
    test_seed_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/skinny_subcells_dom1_serial.md
# skinny_subcells_dom1_serial

Serial first-order DOM-masked SubCells layer for SKINNY-128-384+. It accepts the 128-bit two-share cipher state and runs the 16 cells through one `skinny_sbox8_dom1_rapid_non_pipelined` instance, one cell at a time. Each evaluation gets 25 fresh random bits from an internal LFSR. The result is returned as two 128-bit output shares, and the block sits between the round-state register and the AddConstants/ShiftRows stage.

## Interface
Parameters:
- `SEED`, default 31'h5A5A_1234: LFSR reset value, and the replacement whenever a zero seed is loaded.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: start request; sampled only in IDLE.
- `si0`, in, 128: input share 0; sampled on the accepted `start` edge.
- `si1`, in, 128: input share 1; sampled on the same edge.
- `seed_ld`, in, 1: reload the LFSR from `seed`; honoured only in IDLE.
- `seed`, in, 31: LFSR reload value.
- `so0`, out, 128: output share 0; registered.
- `so1`, out, 128: output share 1; registered.
- `busy`, out, 1: high while the block is evaluating cells.
- `done`, out, 1: one-cycle pulse when `so0`/`so1` become valid.

## Operation
- States: IDLE and EVAL. `cnt[3:0]` is the cell index and `ph` is the phase bit.
- IDLE with `start` high: latch `si0`/`si1` into separate share registers, set `cnt`=0 and `ph`=0, and go to EVAL.
- EVAL, cell `cnt` (cell 0 = bits [127:120], cell 15 = bits [7:0]):
  - The sbox inputs are the selected byte of each share register plus `r` = LFSR[24:0].
  - Inputs and `r` are held stable for 2 cycles, because the sbox is non-pipelined with 2-cycle latency.
  - `ph`=0 → 1.
  - `ph`=1 edge: write the sbox share outputs into byte `cnt` of the `so0`/`so1` registers, step the LFSR, set `ph`=0 and increment `cnt`.
  - On the `cnt`=15 capture edge: return to IDLE, pulse `done`, and deassert `busy`.
- LFSR:
  - 31-bit Fibonacci LFSR, polynomial x^31+x^28+1.
  - Advances 25 steps per cell, unrolled combinationally, so every evaluation uses disjoint randomness.
- `seed_ld` in IDLE loads `seed`; a seed of 0 loads `SEED` instead. `seed_ld` in EVAL is ignored.
- `start` in EVAL is ignored. A `start` in the `done` cycle is accepted, because the block is already in IDLE.
- Outputs hold their value until the next capture or reset. Bytes not yet written during EVAL keep their previous-run values.
- Share separation:
  - Share 0 and share 1 data never share a register or a combinational cone outside the sbox.
  - The byte muxes are per share.
  - No XOR of shares exists in this block.

## Timing
- Reset (async, while `rst_n`=0):
  - `so0`=`so1`=0, `busy`=0, `done`=0.
  - State=IDLE, `cnt`=0, `ph`=0, LFSR=`SEED`.
  - Share registers are cleared to 0.
- Reset mid-EVAL aborts the run with the same values. The next `start` after release restarts from cell 0.
- The edge that accepts `start` is edge E0.
- `busy`=1 from after E0 through E32.
- Cell k is presented after edges E(2k) and E(2k+1), and captured at edge E(2k+2).
- `done`=1 for the single cycle after E32, with `busy`=0 in that cycle. Total latency is 32 cycles.
- Minimum start-to-start spacing is 33 cycles (back-to-back).

## Structure
- Shared package `skinny_dom_pkg` holds:
  - `CELLS`=16, `SBOX_LAT`=2, `RND_W`=25, `LFSR_W`=31.
  - The state enum {IDLE, EVAL}.
- Sub-module `skinny_prng25` holds the LFSR, its 25-step unrolled next-state function, and the zero-seed guard.
- Instantiates the existing `skinny_sbox8_dom1_rapid_non_pipelined` unchanged.

## Test plan
1. All-zero plaintext state, `si1` = random 128-bit mask, `si0` = mask → after `done`, `so0^so1` = 0x6565…65 (S(0x00)=0x65).
2. Plaintext 0xFF…FF, random mask → `so0^so1` = 0xFF…FF (S(0xFF)=0xFF).
3. Sixteen runs covering cell values 0x00–0xFF (run j, cell k = 16j+k), fresh mask each run → every byte equals `skinny_sbox8_lut` output.
4. `start` at E0, second `start` at E10 → `busy` high E1–E32, `done` only after E32, second request ignored; `start` during the `done` cycle → new run completes 32 cycles later.
5. `rst_n` low during cell 7 → `so0`=`so1`=0, `busy`=`done`=0 immediately; then `start` with state 0x0001…0F → correct LUT result.
6. `seed_ld` with `seed`=0, then identical input run twice → LFSR equals `SEED` after the load, `so0` differs between runs, and `so0^so1` is identical and correct.
